led_seq_ctrl: RTL
=================

// Module: led_seq_ctrl
// PURPOSE
//  Controller that sequences the 3-bit LED colour-stepping datapath. It conditions the raw
//  push-button, decides when the datapath advances, and reloads the datapath with a legal
//  colour after reset or when colour 000/111 is seen. It sits between board I/O and the
//  colour register and issues step/load strobes only; it holds no colour state of its own.
// PARAMETERS
//  DEBOUNCE_CYCLES  16      consecutive stable cycles needed before btn_db changes (>=1)
//  STEP_DIV         25      clk cycles per colour step in RUN (>=1)
//  INIT_COLOUR      3'b001  value driven on load_val; must not be 000 or 111
// PORTS
//  clk          in   1  single clock, rising edge
//  rst          in   1  asynchronous, active-low reset (0 = reset)
//  button       in   1  raw asynchronous push-button, active-high
//  mode         in   2  00 MANUAL, 01 HOLD, 10 AUTO, 11 reserved (behaves as HOLD)
//  colour_in    in   3  current colour fed back from the datapath register
//  step         out  1  1-cycle pulse: datapath increments colour on the next edge
//  load         out  1  1-cycle pulse: datapath loads load_val on the next edge
//  load_val     out  3  constant INIT_COLOUR
//  running      out  1  1 while FSM is in S_RUN
//  fix_count    out  8  count of illegal-colour reloads, saturates at 255
// BEHAVIOUR
//  Reset (rst=0, async): step=0, load=0, running=0, fix_count=0, divider=0, btn_db=0,
//   FSM=S_INIT. Reset asserted mid-run kills any pending step immediately.
//  Button path: 2-FF synchroniser -> btn_s; btn_db takes btn_s only after btn_s has held
//   the same value for DEBOUNCE_CYCLES consecutive cycles. Shorter glitches are ignored.
//   btn_rise = btn_db & ~btn_db_q (one cycle).
//  illegal = (colour_in==3'b000) | (colour_in==3'b111).
//  FSM (registered outputs, all strobes one cycle wide):
//   S_INIT: load=1 for one cycle -> S_IDLE.
//   S_IDLE: illegal -> S_FIX. Else MANUAL: btn_rise -> step=1, stay in S_IDLE.
//           AUTO, or HOLD/11 with btn_db=1 -> S_RUN with divider=0. Otherwise stay.
//   S_RUN:  running=1. Divider counts 0..STEP_DIV-1; step=1 in the cycle the count
//           reaches STEP_DIV-1, then the count wraps to 0.
//           illegal -> S_FIX: no step, divider cleared.
//           Run condition false (HOLD and btn_db=0, or mode=MANUAL) -> S_IDLE: divider
//           cleared, no step; a partial interval is discarded, not resumed.
//   S_FIX:  load=1 for one cycle; fix_count += 1 unless it is 255 -> S_IDLE.
//  Priority in any cycle: reset > illegal/fix > leave-run > step. step and load are never
//   high together.
//  Latency: button edge to btn_db = 2 sync + DEBOUNCE_CYCLES cycles. MANUAL step appears
//   one cycle after btn_rise. The first RUN step appears STEP_DIV cycles after entering S_RUN.
//  colour_in is only checked in S_IDLE and S_RUN. After a load, the FSM re-checks it in
//   S_IDLE; a datapath that stays illegal causes repeated fixes until fix_count saturates.
//  Mode changes take effect on the next cycle's evaluation. Mode is assumed quasi-static
//   and is not synchronised.
// STRUCTURE
//  led_ctrl_pkg: MODE_MANUAL/MODE_HOLD/MODE_AUTO localparams; state encodings S_INIT,
//   S_IDLE, S_RUN, S_FIX (2-bit); COLOUR_ALL_OFF=3'b000, COLOUR_ALL_ON=3'b111.
//  Sub-module btn_debounce (synchroniser + stability counter, DEBOUNCE_CYCLES param,
//   outputs btn_db). Divider, FSM and fix counter live in led_seq_ctrl.
// TESTING (bench: DEBOUNCE_CYCLES=3, STEP_DIV=4, behavioural colour register on step/load)
//  1 Release rst, mode=HOLD, button=0 -> load=1 exactly once, colour=001, then no strobes
//    for 50 cycles; running=0.
//  2 HOLD, button held 30 cycles -> running=1 after 2+3+1 cycles, step every 4th cycle,
//    colour 001->010->011...; release -> running=0, colour frozen, no further steps.
//  3 MANUAL, three clean presses (10 cycles high each), plus a 2-cycle glitch -> exactly
//    3 steps, one per press; the glitch produces none.
//  4 AUTO, colour driven to 111 by forcing the register -> next cycle FSM enters S_FIX, one
//    load, colour=001, fix_count=1, no step in the fix cycle; stepping then resumes.
//  5 AUTO running, rst pulled low mid-interval -> step/load/running drop to 0 immediately;
//    after release the S_INIT load repeats and fix_count=0.
//  6 Hold colour_in at 000 permanently -> repeated fix loads; fix_count stops at 255.

Source files
------------

// File: rtl/led_ctrl_pkg.sv
// Shared constants for the LED colour-stepping controller.
//   MODE_*      : encodings of the 2-bit mode input (2'b11 is reserved and acts as HOLD)
//   state_e     : controller FSM states
//   COLOUR_*    : the two colour codes the datapath must never sit on
package led_ctrl_pkg;

  localparam logic [1:0] MODE_MANUAL = 2'b00;
  localparam logic [1:0] MODE_HOLD   = 2'b01;
  localparam logic [1:0] MODE_AUTO   = 2'b10;
  localparam logic [1:0] MODE_RSVD   = 2'b11;

  typedef enum logic [1:0] {
    S_INIT = 2'b00,
    S_IDLE = 2'b01,
    S_RUN  = 2'b10,
    S_FIX  = 2'b11
  } state_e;

  localparam logic [2:0] COLOUR_ALL_OFF = 3'b000;
  localparam logic [2:0] COLOUR_ALL_ON  = 3'b111;

  function automatic logic colour_illegal(input logic [2:0] colour);
    return (colour == COLOUR_ALL_OFF) || (colour == COLOUR_ALL_ON);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-FF synchroniser followed by a stability filter.
// The filtered level only follows the synchronised input once that input has
// differed from it for DEBOUNCE_CYCLES consecutive cycles.
//   clk_i    : clock
//   rst_ni   : asynchronous active-low reset
//   btn_i    : raw asynchronous button, active-high
//   btn_db_o : debounced button level
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic btn_db_o
);

  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]      sync_q, sync_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            db_q, db_d;
  logic            btn_s;

  assign btn_s = sync_q[1];

  always_comb begin
    sync_d = {sync_q[0], btn_i};
    cnt_d  = '0;
    db_d   = db_q;
    // Any cycle where btn_s agrees with the filtered level restarts the count.
    if (btn_s != db_q) begin
      if (cnt_q == CntLast) begin
        db_d = btn_s;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= 2'b00;
      cnt_q  <= '0;
      db_q   <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      db_q   <= db_d;
    end
  end

  assign btn_db_o = db_q;

endmodule

// File: rtl/led_seq_ctrl.sv
// Sequencing controller for the 3-bit LED colour datapath. Issues one-cycle
// step/load strobes; holds no colour state itself.
//   clk_i       : clock, rising edge
//   rst_ni      : asynchronous active-low reset
//   button_i    : raw push-button, active-high
//   mode_i      : 00 MANUAL, 01 HOLD, 10 AUTO, 11 reserved (acts as HOLD)
//   colour_i    : current colour fed back from the datapath
//   step_o      : datapath increments colour on the next edge
//   load_o      : datapath loads load_val_o on the next edge
//   load_val_o  : constant INIT_COLOUR
//   running_o   : high while the FSM is in S_RUN
//   fix_count_o : number of illegal-colour reloads, saturating at 255
module led_seq_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned STEP_DIV        = 25,
  parameter logic [2:0]  INIT_COLOUR     = 3'b001
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       button_i,
  input  logic [1:0] mode_i,
  input  logic [2:0] colour_i,
  output logic       step_o,
  output logic       load_o,
  output logic [2:0] load_val_o,
  output logic       running_o,
  output logic [7:0] fix_count_o
);

  localparam int unsigned DivW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(STEP_DIV - 1);

  state_e          state_q;
  logic            step_q, load_q, running_q, btn_db_q;
  logic [DivW-1:0] div_q;
  logic [7:0]      fix_q;

  logic btn_db, btn_rise, run_cond, is_manual, illegal_chk;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .btn_i   (button_i),
    .btn_db_o(btn_db)
  );

  assign btn_rise  = btn_db & ~btn_db_q;
  assign is_manual = (mode_i == MODE_MANUAL);
  assign run_cond  = (mode_i == MODE_AUTO) ||
                     (((mode_i == MODE_HOLD) || (mode_i == MODE_RSVD)) && btn_db);
  // While a load strobe is out, colour_i still shows the pre-load value; judging it
  // then would trigger a second, spurious fix for the same event.
  assign illegal_chk = colour_illegal(colour_i) & ~load_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_INIT;
      step_q    <= 1'b0;
      load_q    <= 1'b0;
      running_q <= 1'b0;
      btn_db_q  <= 1'b0;
      div_q     <= '0;
      fix_q     <= '0;
    end else begin
      step_q    <= 1'b0;
      load_q    <= 1'b0;
      running_q <= 1'b0;
      btn_db_q  <= btn_db;
      unique case (state_q)
        S_INIT: begin
          load_q  <= 1'b1;
          state_q <= S_IDLE;
        end
        S_IDLE: begin
          if (illegal_chk) begin
            state_q <= S_FIX;
          end else if (run_cond) begin
            state_q   <= S_RUN;
            running_q <= 1'b1;
            div_q     <= '0;
          end else if (is_manual && btn_rise) begin
            step_q <= 1'b1;
          end
        end
        S_RUN: begin
          if (illegal_chk) begin
            state_q <= S_FIX;
            div_q   <= '0;
          end else if (!run_cond) begin
            // Partial interval is dropped; the next run starts a fresh count.
            state_q <= S_IDLE;
            div_q   <= '0;
          end else begin
            running_q <= 1'b1;
            if (div_q == DivLast) begin
              step_q <= 1'b1;
              div_q  <= '0;
            end else begin
              div_q <= div_q + DivW'(1);
            end
          end
        end
        S_FIX: begin
          load_q  <= 1'b1;
          state_q <= S_IDLE;
          if (fix_q != 8'hFF) begin
            fix_q <= fix_q + 8'd1;
          end
        end
        default: state_q <= S_INIT;
      endcase
    end
  end

  assign step_o      = step_q;
  assign load_o      = load_q;
  assign load_val_o  = INIT_COLOUR;
  assign running_o   = running_q;
  assign fix_count_o = fix_q;

endmodule
